// File: rtl/saxi_test.sv
// AXI3 slave responder/checker: checks generator write bursts, answers reads with address-derived data.
// Optional SAXI_TEST_STALL_EN gates awready/wready/arready with an 8-bit LFSR.
module saxi_test #(
  parameter int          SIDW   = 12,
  parameter int          SAW    = 32,
  parameter int          SDW    = 32,
  parameter int          SSTW   = 4,
  parameter logic [31:0] RD_XOR = 32'hA5A5A5A5
) (
  input  logic            s_axi_aclk,
  input  logic            s_axi_areset,
  input  logic [SIDW-1:0] s_axi_awid,
  input  logic [SAW-1:0]  s_axi_awaddr,
  input  logic [3:0]      s_axi_awlen,
  input  logic            s_axi_awvalid,
  output logic            s_axi_awready,
  input  logic [SIDW-1:0] s_axi_wid,
  input  logic [SDW-1:0]  s_axi_wdata,
  input  logic [SSTW-1:0] s_axi_wstrb,
  input  logic            s_axi_wlast,
  input  logic            s_axi_wvalid,
  output logic            s_axi_wready,
  output logic [SIDW-1:0] s_axi_bid,
  output logic [1:0]      s_axi_bresp,
  output logic            s_axi_bvalid,
  input  logic            s_axi_bready,
  input  logic [SIDW-1:0] s_axi_arid,
  input  logic [SAW-1:0]  s_axi_araddr,
  input  logic [3:0]      s_axi_arlen,
  input  logic            s_axi_arvalid,
  output logic            s_axi_arready,
  output logic [SIDW-1:0] s_axi_rid,
  output logic [SDW-1:0]  s_axi_rdata,
  output logic [1:0]      s_axi_rresp,
  output logic            s_axi_rlast,
  output logic            s_axi_rvalid,
  input  logic            s_axi_rready,
  output logic            error
);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t        r_wstate;
  r_state_t        r_rstate;
  logic            r_aw_en, r_w_en, r_ar_en;
  logic            r_bvalid;
  logic [1:0]      r_bresp;
  logic [SIDW-1:0] r_bid, r_wid_cap;
  logic [3:0]      r_wlen, r_wbeat;
  logic [SAW-1:0]  r_exp_awaddr;
  logic [SDW-1:0]  r_exp_wdata;
  logic            r_burst_err, r_error;
  logic            r_rvalid, r_rlast;
  logic [SIDW-1:0] r_rid;
  logic [SAW-1:0]  r_raddr;
  logic [3:0]      r_rlen, r_rbeat;
  logic [SDW-1:0]  r_rdata;

  logic            w_gate;
  logic            w_awready, w_wready, w_arready;
  logic            w_aw_hs, w_w_hs, w_ar_hs, w_r_hs;
  logic            w_aw_bad, w_beat_last, w_beat_bad;
  logic [SAW-1:0]  w_wbytes, w_raddr_next, w_ar_xor, w_rn_xor;

`ifdef SAXI_TEST_STALL_EN
  logic [7:0] r_lfsr;
  // Fibonacci LFSR for x^8+x^6+x^5+x^4+1; primitive, so it never reaches zero from seed 1.
  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) r_lfsr <= 8'h01;
    else              r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  end
  assign w_gate = r_lfsr[0];
`else
  assign w_gate = 1'b1;
`endif

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // the slave never waits for valid before raising ready, and holds R/B payload while ready is low.
  assign w_awready = r_aw_en & w_gate;
  assign w_wready  = r_w_en & w_gate;
  assign w_arready = r_ar_en & w_gate;
  assign w_aw_hs   = s_axi_awvalid & w_awready;
  assign w_w_hs    = s_axi_wvalid & w_wready;
  assign w_ar_hs   = s_axi_arvalid & w_arready;
  assign w_r_hs    = r_rvalid & s_axi_rready;

  assign w_aw_bad    = (s_axi_awaddr != r_exp_awaddr);
  assign w_beat_last = (r_wbeat == r_wlen);
  assign w_beat_bad  = (s_axi_wdata != r_exp_wdata) || (s_axi_wstrb != {SSTW{1'b1}}) ||
                       (s_axi_wid != r_wid_cap) || (s_axi_wlast != w_beat_last);
  assign w_wbytes    = {{(SAW-7){1'b0}}, ({1'b0, r_wlen} + 5'd1), 2'b00};

  assign w_raddr_next = r_raddr + SAW'(4);
  assign w_ar_xor     = s_axi_araddr ^ SAW'(RD_XOR);
  assign w_rn_xor     = w_raddr_next ^ SAW'(RD_XOR);

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      r_wstate     <= W_IDLE;
      r_aw_en      <= 1'b0;
      r_w_en       <= 1'b0;
      r_bvalid     <= 1'b0;
      r_bresp      <= 2'b00;
      r_bid        <= '0;
      r_wid_cap    <= '0;
      r_wlen       <= '0;
      r_wbeat      <= '0;
      r_exp_awaddr <= '0;
      r_exp_wdata  <= '1;
      r_burst_err  <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          r_aw_en <= 1'b1;
          if (w_aw_hs) begin
            r_aw_en     <= 1'b0;
            r_w_en      <= 1'b1;
            r_wid_cap   <= s_axi_awid;
            r_wlen      <= s_axi_awlen;
            r_wbeat     <= '0;
            r_burst_err <= w_aw_bad;
            if (w_aw_bad) r_error <= 1'b1;
            r_wstate    <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_w_hs) begin
            r_exp_wdata <= r_exp_wdata - SDW'(1);
            r_wbeat     <= r_wbeat + 4'd1;
            if (w_beat_bad) begin
              r_burst_err <= 1'b1;
              r_error     <= 1'b1;
            end
            if (w_beat_last) begin
              r_w_en       <= 1'b0;
              r_exp_awaddr <= r_exp_awaddr + w_wbytes;
              r_bvalid     <= 1'b1;
              r_bid        <= r_wid_cap;
              r_bresp      <= (r_burst_err || w_beat_bad) ? 2'b10 : 2'b00;
              r_wstate     <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            r_bvalid <= 1'b0;
            r_wstate <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      r_rstate <= R_IDLE;
      r_ar_en  <= 1'b0;
      r_rvalid <= 1'b0;
      r_rlast  <= 1'b0;
      r_rid    <= '0;
      r_raddr  <= '0;
      r_rlen   <= '0;
      r_rbeat  <= '0;
      r_rdata  <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          r_ar_en <= 1'b1;
          if (w_ar_hs) begin
            r_ar_en  <= 1'b0;
            r_rid    <= s_axi_arid;
            r_raddr  <= s_axi_araddr;
            r_rlen   <= s_axi_arlen;
            r_rbeat  <= '0;
            r_rvalid <= 1'b1;
            r_rdata  <= w_ar_xor[SDW-1:0];
            r_rlast  <= (s_axi_arlen == 4'd0);
            r_rstate <= R_DATA;
          end
        end
        R_DATA: begin
          if (w_r_hs) begin
            if (r_rlast) begin
              r_rvalid <= 1'b0;
              r_rlast  <= 1'b0;
              r_rstate <= R_IDLE;
            end else begin
              r_raddr <= w_raddr_next;
              r_rbeat <= r_rbeat + 4'd1;
              r_rdata <= w_rn_xor[SDW-1:0];
              r_rlast <= ((r_rbeat + 4'd1) == r_rlen);
            end
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign s_axi_awready = w_awready;
  assign s_axi_wready  = w_wready;
  assign s_axi_arready = w_arready;
  assign s_axi_bid     = r_bid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_rid     = r_rid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = 2'b00;
  assign s_axi_rlast   = r_rlast;
  assign s_axi_rvalid  = r_rvalid;
  assign error         = r_error;

endmodule
